data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Word-addressed data-memory responder: the memory-side end of the core's load/store control interface (mem_read, mem_write, address, write data).
- Accepts one load or store request at a time and services it after a programmable number of wait states.
- Stalls the core with a busy signal while the request is in progress, then returns a one-cycle completion pulse carrying read data or an error flag.
- Sits between the core's execute/memory stage and an internal synchronous RAM array.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; memory depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles spent in WAIT before the access commits; range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  load request; level, held until ready.
- mem_write  input  1  store request; level, held until ready.
- addr  input  32  byte address from the ALU result.
- wdata  input  32  store data.
- rdata  output  32  load data; registered; valid when ready=1 and the operation was a load.
- ready  output  1  one-cycle completion pulse.
- stall  output  1  busy indication to the core; freeze PC and pipeline while 1.
- err  output  1  valid with ready; 1 = request rejected.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, on port rst, clocked by clk.
- Reset values: state=IDLE, ready=0, err=0, rdata=0, stall=0, wait counter=0. RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is 1, capture addr, wdata and the operation, load counter=WAIT_STATES, and go to WAIT.
  - stall is combinational = mem_read|mem_write in IDLE, so the core stalls in the request cycle.
- WAIT:
  - stall=1.
  - If counter==0, perform the access and go to RESP; otherwise decrement the counter.
  - WAIT therefore lasts WAIT_STATES+1 cycles.
- Access, performed on the WAIT exit edge:
  - Store: mem[addr[ADDR_WIDTH+1:2]] <= captured wdata.
  - Load: rdata <= mem[addr[ADDR_WIDTH+1:2]].
- RESP:
  - ready=1 and stall=0 for exactly one cycle, then go to IDLE unconditionally.
  - err is valid this cycle and is 0 elsewhere.
- Latency: request seen at cycle 0 gives ready at cycle WAIT_STATES+2. A request present in the IDLE cycle after RESP is treated as a new request.
- Inputs changing after capture are ignored; only the captured values are used.
- Error cases (state flow unchanged; the access is suppressed, so no RAM write and rdata keeps its prior value; err=1 in RESP):
  - Misaligned address: addr[1:0]!=0.
  - Both mem_read and mem_write high at capture.
- Address range: bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the memory size. No error is raised.
- rdata holds its last load value until the next successful load. Stores and errors do not modify it.
- Reset mid-operation: immediate return to IDLE. A store not yet committed is dropped. A store committed on the same edge as rst is retained.
- stall and ready are never 1 in the same cycle.

Test Plan:
- WAIT_STATES=1: store 0xDEADBEEF to 0x10, then load 0x10.
  - Each ready arrives 3 cycles after its request.
  - stall=1 for cycles 0–2.
  - Load returns rdata=0xDEADBEEF with err=0.
- WAIT_STATES=0: load from 0x04 after a store of 0x12345678 to 0x04 → ready at cycle 2, rdata=0x12345678.
- Store to 0x06 (misaligned) → ready with err=1. A following load of 0x04 still returns the old value, and rdata is unchanged in the error cycle.
- mem_read=mem_write=1 at addr 0x08 → err=1, no RAM write, rdata unchanged.
- ADDR_WIDTH=10: store 0xA5A5A5A5 to 0x1000, then load 0x0000 → rdata=0xA5A5A5A5 (wrap).
- Assert rst one cycle into WAIT of a store of 0x11111111 to 0x20:
  - Outputs return to 0 the next cycle, state is IDLE.
  - A subsequent load of 0x20 returns the pre-store contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder for the core's load/store port.
// One request at a time: capture in IDLE, count wait states in WAIT,
// commit the access on the WAIT exit edge, pulse ready for one RESP cycle.
//
// Handshake: mem_read / mem_write are level requests held by the core until
// it sees ready. stall is high from the request cycle through the last WAIT
// cycle. ready is a single-cycle pulse with stall low, and err / rdata are
// valid alongside it. A request still present in the IDLE cycle after RESP
// starts a new transaction.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = WAIT, 2 = RESP).
// ADDR_WIDTH must be at most 29. WAIT_STATES must be in the range 0..15.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   cap_idx;
  logic [31:0]             cap_wdata;
  logic                    cap_write;
  logic                    cap_bad;
  logic                    request;
  logic                    commit;
  logic [31:0]             mem [0:(2**ADDR_WIDTH)-1];

  // Byte-offset bits and the bits above the word index play no part in the access.
  logic addr_unused;
  assign addr_unused = ^{addr[31:ADDR_WIDTH+2]};

  assign request   = mem_read | mem_write;
  // The access happens on the edge that leaves WAIT, unless the request was rejected.
  assign commit    = (state == WAIT) && (cnt == 4'd0) && !cap_bad;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    ready      = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        stall = request;
        if (request) next_state = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) next_state = RESP;
      end
      RESP: begin
        ready      = 1'b1;
        err        = cap_bad;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture, wait-state countdown and load data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
      cap_write <= 1'b0;
      cap_bad   <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      if (state == IDLE && request) begin
        cap_idx   <= addr[ADDR_WIDTH+1:2];
        cap_wdata <= wdata;
        cap_write <= mem_write;
        cap_bad   <= (addr[1:0] != 2'b00) || (mem_read && mem_write);
        cnt       <= 4'(WAIT_STATES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !cap_write) rdata <= mem[cap_idx];
    end
  end

  // RAM write port. It is not gated by rst, so a store committing on the reset edge still lands.
  always_ff @(posedge clk) begin
    if (commit && cap_write) mem[cap_idx] <= cap_wdata;
  end

endmodule
